ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshaking. It generalises the fixed 16-bit combinational Kogge-Stone adder to any power-of-two width and a configurable number of prefix levels per pipeline stage. It adds a subtract mode and a signed-overflow flag. It sits in the datapath wherever a wide add must meet timing at the core clock, and it accepts one operation per cycle under backpressure.

---
 rtl/ks_adder_pkg.sv | 29 ++
 rtl/ks_prefix_level.sv | 26 ++
 rtl/ks_adder_pipe.sv | 177 +++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_adder_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: width/latency math
// and the parameter legality rule used at elaboration.
package ks_adder_pkg;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Cycles from accept edge to out_valid with no stall.
    function automatic int ks_lat(input int width, input int lps);
        return (clog2(width) + lps - 1) / lps;
    endfunction

    // WIDTH must be a power of two in 4..64; LPS in 1..log2(WIDTH).
    function automatic bit ks_params_ok(input int width, input int lps);
        return (width >= 4) && (width <= 64) && ((1 << clog2(width)) == width) &&
               (lps >= 1) && (lps <= clog2(width));
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level over N (G,P) pairs.
// Bit i merges with bit i-SPAN when that partner exists; lower bits pass through.
module ks_prefix_level
    import ks_adder_pkg::*;
#(
    parameter int N    = 17,
    parameter int SPAN = 1
) (
    input  logic [N-1:0] i_g,
    input  logic [N-1:0] i_p,
    output logic [N-1:0] o_g,
    output logic [N-1:0] o_p
);

    // Black cells for bits with a partner SPAN below, pass-through otherwise
    always_comb begin
        // NOTE: defaults first so every bit is assigned on every path; no latch can form.
        o_g = i_g;
        o_p = i_p;
        for (int i = SPAN; i < N; i++) begin
            o_g[i] = i_g[i] | (i_p[i] & i_g[i-SPAN]);
            o_p[i] = i_p[i] & i_p[i-SPAN];
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Vectors carry WIDTH+1 (G,P) pairs: index 0 is a virtual bit holding the
// carry-in as its generate (P=0), index j>0 is operand bit j-1. A single
// global enable advances every stage together; bubbles are kept.
module ks_adder_pipe
    import ks_adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = clog2(WIDTH);
    localparam int N = WIDTH + 1;

    if (!ks_params_ok(WIDTH, LEVELS_PER_STAGE)) begin : g_param_check
        $error("ks_adder_pipe: WIDTH must be a power of two in 4..64 and LEVELS_PER_STAGE in 1..log2(WIDTH)");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bm;
    logic             w_c0;
    logic [N-1:0]     w_g0;
    logic [N-1:0]     w_p0;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // The whole pipe moves only when the output slot is empty or being taken.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage 0: invert b for subtract, force carry-in, form bitwise generate/propagate
    always_comb begin
        w_bm = sub ? ~b : b;
        w_c0 = sub | cin;
        w_g0 = {a & w_bm, w_c0};
        w_p0 = {a ^ w_bm, 1'b0};
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        // Level inputs
        logic [N-1:0]     w_gi, w_pi;
        logic [WIDTH-1:0] w_poi;
        logic             w_vi, w_ami, w_bmi;
        // Combinational level outputs
        logic [N-1:0]     w_go, w_po;
        // Level outputs after the optional pipeline register
        logic [N-1:0]     w_gq, w_pq;
        logic [WIDTH-1:0] w_poq;
        logic             w_vq, w_amq, w_bmq;

        if (k == 0) begin : g_first
            assign w_gi  = w_g0;
            assign w_pi  = w_p0;
            assign w_poi = w_p0[N-1:1];
            assign w_vi  = in_valid;
            assign w_ami = a[WIDTH-1];
            assign w_bmi = w_bm[WIDTH-1];
        end else begin : g_chain
            assign w_gi  = g_lvl[k-1].w_gq;
            assign w_pi  = g_lvl[k-1].w_pq;
            assign w_poi = g_lvl[k-1].w_poq;
            assign w_vi  = g_lvl[k-1].w_vq;
            assign w_ami = g_lvl[k-1].w_amq;
            assign w_bmi = g_lvl[k-1].w_bmq;
        end

        ks_prefix_level #(
            .N    (N),
            .SPAN (1 << k)
        ) u_level (
            .i_g (w_gi),
            .i_p (w_pi),
            .o_g (w_go),
            .o_p (w_po)
        );

        if ((k != L - 1) && (((k + 1) % LEVELS_PER_STAGE) == 0)) begin : g_reg
            logic [N-1:0]     r_g, r_p;
            logic [WIDTH-1:0] r_po;
            logic             r_v, r_am, r_bm;

            // Internal pipeline register; loads from the level above on every advance
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: data registers are cleared too, not only valid bits, so nothing stale survives reset.
                if (!rst_n) begin
                    r_g  <= '0;
                    r_p  <= '0;
                    r_po <= '0;
                    r_v  <= 1'b0;
                    r_am <= 1'b0;
                    r_bm <= 1'b0;
                end else if (w_adv) begin
                    // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
                    r_g  <= w_go;
                    r_p  <= w_po;
                    r_po <= w_poi;
                    r_v  <= w_vi;
                    r_am <= w_ami;
                    r_bm <= w_bmi;
                end
            end

            assign w_gq  = r_g;
            assign w_pq  = r_p;
            assign w_poq = r_po;
            assign w_vq  = r_v;
            assign w_amq = r_am;
            assign w_bmq = r_bm;
        end else begin : g_pass
            // The last level always falls through to the final logic and output register.
            assign w_gq  = w_go;
            assign w_pq  = w_po;
            assign w_poq = w_poi;
            assign w_vq  = w_vi;
            assign w_amq = w_ami;
            assign w_bmq = w_bmi;
        end
    end

    logic [N-1:0]     w_gf, w_pf, w_c;
    logic [WIDTH-1:0] w_pof, w_sum;
    logic             w_vf, w_amf, w_bmf, w_cout, w_ovf;

    assign w_gf  = g_lvl[L-1].w_gq;
    assign w_pf  = g_lvl[L-1].w_pq;
    assign w_pof = g_lvl[L-1].w_poq;
    assign w_vf  = g_lvl[L-1].w_vq;
    assign w_amf = g_lvl[L-1].w_amq;
    assign w_bmf = g_lvl[L-1].w_bmq;

    // Final: close every group against the carry-in, then sum, carry-out and overflow.
    // Groups already reaching index 0 have P=0, so only the top group is changed.
    always_comb begin
        w_c    = w_gf | (w_pf & {N{w_gf[0]}});
        w_sum  = w_pof ^ w_c[N-2:0];
        w_cout = w_c[N-1];
        w_ovf  = (w_amf == w_bmf) && (w_sum[WIDTH-1] != w_amf);
    end

    // Output register; holds steady while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_vf;
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe at WIDTH=16, LEVELS_PER_STAGE=2.
// A queue of arithmetic results (plain integer add/subtract) is compared
// against every output beat; directed cases pin literal values and latency.
module tb_ks_adder_pipe;

    localparam int W   = 16;
    localparam int LPS = 2;
    localparam int LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W+2:0] held;

    ks_adder_pipe #(
        .WIDTH            (W),
        .LEVELS_PER_STAGE (LPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, cout, sum} from plain integer math.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        longint ux, uy, sx, sy, ur, sr, smax, smin;
        logic   co, ov;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (s) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + longint'(ci);
            co = ((ur >> W) != 0);
            sr = sx + sy + longint'(ci);
        end
        ov = (sr > smax) || (sr < smin);
        return {ov, co, ur[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) check("stall_hold", {out_valid, ovf, cout, sum}, held);
            if (out_valid) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("result", {ovf, cout, sum}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, ovf, cout, sum};
        end
    end

    // One isolated beat: out_valid must rise exactly LAT cycles after accept.
    task automatic run_one(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tcin, input logic tsub,
                           input logic [W-1:0] esum, input logic ecout, input logic eovf);
        a         = ta;
        b         = tb_v;
        cin       = tcin;
        sub       = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= LAT; cyc++) begin
            @(negedge clk);
            check({name, "_valid"}, out_valid, cyc == LAT);
        end
        check({name, "_sum"}, sum, esum);
        check({name, "_cout"}, cout, ecout);
        check({name, "_ovf"}, ovf, eovf);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_sum"}, sum, '0);
        check({name, "_cout"}, cout, 1'b0);
        check({name, "_ovf"}, ovf, 1'b0);
        check({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int beat;
        int got;
        int stall_left;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        run_one("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("ovf_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: 4 beats, 3-cycle stall once the first result appears
        beat       = 0;
        got        = 0;
        stall_left = 3;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid && stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (beat < 4);
            a        = W'(beat + 1);
            b        = W'(beat + 1);
            cin      = 1'b0;
            sub      = 1'b0;
            @(negedge clk);
            if (out_valid && !out_ready) check("bp_in_ready", in_ready, 1'b0);
            if (in_valid && in_ready) beat++;
            if (out_valid && out_ready) begin
                check("bp_sum", sum, W'(2 * (got + 1)));
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_results", got, 4);
        check("bp_stall_used", stall_left, 0);
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        check("bp_no_duplicate", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h1111;
        cin       = 1'b0;
        sub       = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h0F0F;
        b = 16'h0101;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_inflight_valid", out_valid, 1'b1);
        check("rst_inflight_sum", sum, 16'h2345);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        run_one("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Random traffic with random backpressure, checked by the compare process
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            @(posedge clk);
            #1;
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
